// File: rtl/sram_arbiter_mc.sv
// sram_arbiter_mc: shares one external SRAM between VGA scan-out (absolute priority) and
// NUM_CLIENTS request/grant clients through a one-entry access register.
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// by default clients are served round-robin.
module sram_arbiter_mc #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              I_CLK,
    input  logic                              I_RST,
    input  logic                              I_VGA_READ,
    input  logic [ADDR_WIDTH-1:0]             I_VGA_ADDR,
    output logic [DATA_WIDTH-1:0]             O_VGA_DATA,
    input  logic [NUM_CLIENTS-1:0]            I_REQ,
    input  logic [NUM_CLIENTS-1:0]            I_WE,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] I_ADDR,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] I_WDATA,
    output logic [NUM_CLIENTS-1:0]            O_GNT,
    output logic [NUM_CLIENTS-1:0]            O_RVALID,
    output logic [DATA_WIDTH-1:0]             O_RDATA,
    inout  wire  [DATA_WIDTH-1:0]             IO_SRAM_DQ,
    output logic [ADDR_WIDTH-1:0]             O_SRAM_ADDR,
    output logic                              O_SRAM_UB_N,
    output logic                              O_SRAM_LB_N,
    output logic                              O_SRAM_CE_N,
    output logic                              O_SRAM_WE_N,
    output logic                              O_SRAM_OE_N
);

    localparam int IDW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic                   ar_valid_q, ar_valid_d;
    logic [IDW-1:0]         ar_id_q, ar_id_d;
    logic                   ar_we_q, ar_we_d;
    logic [ADDR_WIDTH-1:0]  ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0]  ar_wdata_q, ar_wdata_d;
    logic [NUM_CLIENTS-1:0] rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]  addr_last_q, addr_last_d;

    logic                   grant;
    logic                   drain;
    logic                   win_found;
    logic [IDW-1:0]         win_id;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   dq_oe;
    logic [ADDR_WIDTH-1:0]  sram_addr;

    // Reset blocks both grant and drain so an access caught by reset never reaches the pins.
    assign drain = ar_valid_q && !I_VGA_READ && !I_RST;
    assign grant = win_found && !I_VGA_READ && !I_RST && (!ar_valid_q || drain);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (I_REQ[i]) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
    end
`else
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_CLIENTS - 1);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] cand;

    // Search starts one past the last granted client and wraps at NUM_CLIENTS.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = rr_ptr_q;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
            if (!win_found && I_REQ[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign rr_ptr_d = grant ? win_id : rr_ptr_q;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            rr_ptr_q <= LAST_ID;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (win_id == IDW'(i)) begin
                sel_we    = I_WE[i];
                sel_addr  = I_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = I_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        O_GNT = '0;
        if (grant) begin
            O_GNT[win_id] = 1'b1;
        end
    end

    // A grant may refill the register in the same cycle it drains.
    always_comb begin
        ar_valid_d = ar_valid_q;
        ar_id_d    = ar_id_q;
        ar_we_d    = ar_we_q;
        ar_addr_d  = ar_addr_q;
        ar_wdata_d = ar_wdata_q;
        if (grant) begin
            ar_valid_d = 1'b1;
            ar_id_d    = win_id;
            ar_we_d    = sel_we;
            ar_addr_d  = sel_addr;
            ar_wdata_d = sel_wdata;
        end else if (drain) begin
            ar_valid_d = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (drain && !ar_we_q) begin
            rvalid_d[ar_id_q] = 1'b1;
            rdata_d           = IO_SRAM_DQ;
        end
    end

    always_comb begin
        sram_addr = addr_last_q;
        if (I_VGA_READ) begin
            sram_addr = I_VGA_ADDR;
        end else if (drain) begin
            sram_addr = ar_addr_q;
        end
    end

    assign addr_last_d = sram_addr;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            ar_valid_q  <= 1'b0;
            ar_id_q     <= '0;
            ar_we_q     <= 1'b0;
            ar_addr_q   <= '0;
            ar_wdata_q  <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            addr_last_q <= '0;
        end else begin
            ar_valid_q  <= ar_valid_d;
            ar_id_q     <= ar_id_d;
            ar_we_q     <= ar_we_d;
            ar_addr_q   <= ar_addr_d;
            ar_wdata_q  <= ar_wdata_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            addr_last_q <= addr_last_d;
        end
    end

    assign dq_oe       = drain && ar_we_q;
    assign IO_SRAM_DQ  = dq_oe ? ar_wdata_q : {DATA_WIDTH{1'bz}};
    assign O_SRAM_ADDR = sram_addr;
    assign O_SRAM_WE_N = !dq_oe;
    assign O_SRAM_OE_N = !(I_VGA_READ || (drain && !ar_we_q));
    assign O_SRAM_UB_N = 1'b0;
    assign O_SRAM_LB_N = 1'b0;
    assign O_SRAM_CE_N = 1'b0;
    assign O_VGA_DATA  = I_VGA_READ ? IO_SRAM_DQ : '0;
    assign O_RVALID    = rvalid_q;
    assign O_RDATA     = rdata_q;

endmodule

// File: tb/tb_sram_arbiter_mc.sv
// Directed bench for sram_arbiter_mc with a small behavioural SRAM on the pins;
// memory word at address a is preloaded with 16'hA000 + a.
module tb_sram_arbiter_mc;

    localparam int NC = 4;
    localparam int AW = 18;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic              vga;
    logic [AW-1:0]     vga_addr;
    logic [DW-1:0]     vga_data;
    logic [NC-1:0]     req;
    logic [NC-1:0]     we_v;
    logic [NC*AW-1:0]  addr_v;
    logic [NC*DW-1:0]  wdata_v;
    logic [NC-1:0]     gnt;
    logic [NC-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    wire  [DW-1:0]     sram_dq;
    logic [AW-1:0]     sram_addr;
    logic              ub_n, lb_n, ce_n, we_n, oe_n;
    logic              load_en;
    logic [DW-1:0]     mem [0:1023];

    int n_cmp = 0;
    int n_mis = 0;

    sram_arbiter_mc #(.NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .I_CLK      (clk),
        .I_RST      (rst),
        .I_VGA_READ (vga),
        .I_VGA_ADDR (vga_addr),
        .O_VGA_DATA (vga_data),
        .I_REQ      (req),
        .I_WE       (we_v),
        .I_ADDR     (addr_v),
        .I_WDATA    (wdata_v),
        .O_GNT      (gnt),
        .O_RVALID   (rvalid),
        .O_RDATA    (rdata),
        .IO_SRAM_DQ (sram_dq),
        .O_SRAM_ADDR(sram_addr),
        .O_SRAM_UB_N(ub_n),
        .O_SRAM_LB_N(lb_n),
        .O_SRAM_CE_N(ce_n),
        .O_SRAM_WE_N(we_n),
        .O_SRAM_OE_N(oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'hA000 + 16'(i);
        end else if (!we_n) begin
            mem[sram_addr[9:0]] <= sram_dq;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we_v[i]           = we;
        addr_v[i*AW +: AW] = a;
        wdata_v[i*DW +: DW] = d;
    endtask

    int gid;
    int rid;

    initial begin
        rst = 1'b1; load_en = 1'b1; vga = 1'b0; vga_addr = '0;
        req = '0; we_v = '0; addr_v = '0; wdata_v = '0;

        // Power-on reset
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_gnt", gnt, 0);
            check("rst_rvalid", rvalid, 0);
            check("rst_rdata", rdata, 0);
            check("rst_we_n", we_n, 1);
            check("rst_oe_n", oe_n, 1);
            check("rst_addr", sram_addr, 0);
            check("rst_ce_n", ce_n, 0);
            tick();
            load_en = 1'b0;
        end
        rst = 1'b0;

        // Client 2 writes 0xBEEF to 0x00123 and reads it back
        set_client(2, 1'b1, 18'h00123, 16'hBEEF);
        req = 4'b0100;
        @(negedge clk); check("wr_gnt", gnt, 4'b0100);
        tick(); req = '0;
        @(negedge clk);
        check("wr_we_n", we_n, 0);
        check("wr_oe_n", oe_n, 1);
        check("wr_addr", sram_addr, 18'h00123);
        check("wr_dq", sram_dq, 16'hBEEF);
        tick();
        set_client(2, 1'b0, 18'h00123, 16'h0000);
        req = 4'b0100;
        @(negedge clk); check("rd_gnt", gnt, 4'b0100);
        tick(); req = '0;
        @(negedge clk);
        check("rd_oe_n", oe_n, 0);
        check("rd_we_n", we_n, 1);
        check("rd_rvalid_early", rvalid, 0);
        tick();
        @(negedge clk);
        check("rd_rvalid", rvalid, 4'b0100);
        check("rd_rdata", rdata, 16'hBEEF);
        tick();
        @(negedge clk);
        check("rd_rvalid_off", rvalid, 0);
        check("rd_rdata_hold", rdata, 16'hBEEF);
        tick();

        // Reset while client 3's read sits in the access register
        set_client(3, 1'b0, 18'h00077, 16'h0000);
        req = 4'b1000;
        @(negedge clk); check("rm_gnt", gnt, 4'b1000);
        tick(); req = 4'b0001; rst = 1'b1;
        @(negedge clk);
        check("rm_gnt_blk", gnt, 0);
        check("rm_oe_n", oe_n, 1);
        check("rm_we_n", we_n, 1);
        tick();
        @(negedge clk);
        check("rm2_gnt", gnt, 0);
        check("rm2_rvalid", rvalid, 0);
        check("rm2_rdata", rdata, 0);
        check("rm2_addr", sram_addr, 0);
        check("rm2_oe_n", oe_n, 1);
        tick(); rst = 1'b0; req = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); check("rm_no_rvalid", rvalid, 0);
            tick();
        end

        // All four clients request reads continuously
        for (int i = 0; i < NC; i++) set_client(i, 1'b0, 18'(16 + i), 16'h0000);
        for (int k = 0; k < 10; k++) begin
            req = (k < 8) ? 4'hF : 4'h0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
            gid = 0;
            rid = 0;
`else
            gid = k % 4;
            rid = (k + 2) % 4;
`endif
            @(negedge clk);
            check("rr_gnt", gnt, (k < 8) ? (32'd1 << gid) : 0);
            if (k >= 2) begin
                check("rr_rvalid", rvalid, 32'd1 << rid);
                check("rr_rdata", rdata, 16'hA010 + 16'(rid));
            end
            tick();
        end
        req = '0;

        // VGA preempts client 1's granted read for 3 cycles; client 3 waits
        set_client(1, 1'b0, 18'h00055, 16'h0000);
        set_client(3, 1'b1, 18'h00300, 16'h1234);
        req = 4'b0010;
        @(negedge clk); check("vg_gnt1", gnt, 4'b0010);
        tick();
        req = 4'b1000; vga = 1'b1;
        for (int j = 0; j < 3; j++) begin
            vga_addr = 18'h00200 + 18'(j);
            @(negedge clk);
            check("vg_addr", sram_addr, 18'h00200 + 18'(j));
            check("vg_gnt", gnt, 0);
            check("vg_oe_n", oe_n, 0);
            check("vg_we_n", we_n, 1);
            check("vg_data", vga_data, 16'hA200 + 16'(j));
            check("vg_rvalid", rvalid, 0);
            tick();
        end
        vga = 1'b0;
        @(negedge clk);
        check("vg_drain_addr", sram_addr, 18'h00055);
        check("vg_drain_oe_n", oe_n, 0);
        check("vg_gnt3", gnt, 4'b1000);
        check("vg_vdata_off", vga_data, 0);
        tick(); req = '0;
        @(negedge clk);
        check("vg_rvalid1", rvalid, 4'b0010);
        check("vg_rdata", rdata, 16'hA055);
        check("vg_wr_we_n", we_n, 0);
        check("vg_wr_addr", sram_addr, 18'h00300);
        tick();
        @(negedge clk);
        check("vg_rvalid_off", rvalid, 0);
        check("vg_mem_wr", mem[10'h300], 16'h1234);
        tick();

        // Client 0 alone reads addresses 0..4 back to back
        for (int k = 0; k < 8; k++) begin
            req = (k < 5) ? 4'b0001 : 4'b0000;
            set_client(0, 1'b0, (k < 5) ? 18'(k) : 18'h00004, 16'h0000);
            @(negedge clk);
            check("b2b_gnt", gnt, (k < 5) ? 4'b0001 : 4'b0000);
            if (k >= 2 && k < 7) begin
                check("b2b_rvalid", rvalid, 4'b0001);
                check("b2b_rdata", rdata, 16'hA000 + 16'(k - 2));
            end else begin
                check("b2b_rvalid_off", rvalid, 0);
            end
            tick();
        end

        // Idle bus: strobes deasserted, address holds the last value
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_we_n", we_n, 1);
            check("idle_oe_n", oe_n, 1);
            check("idle_gnt", gnt, 0);
            check("idle_addr", sram_addr, 18'h00004);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sram_arbiter_mc.md
# sram_arbiter_mc

Parametrised successor to the single-GPU framebuffer SRAM multiplexer. It arbitrates one external 16-bit SRAM between the VGA scan-out read port and NUM_CLIENTS independent request/grant clients, such as the rasteriser, GPU fill unit and CPU memory-mapped framebuffer port. The VGA port has absolute priority. Clients are served round-robin through a one-entry access register, and each read returns a tagged valid pulse. The block sits between the GPU-side stages and the SRAM pins at top level.

## Interface
- NUM_CLIENTS, 4: number of request/grant clients, 1..8
- ADDR_WIDTH, 18: SRAM word address width
- DATA_WIDTH, 16: SRAM data width
- I_CLK  in  1  system clock (pll_c0 domain); one clock, all logic on rising edge
- I_RST  in  1  synchronous, active-high reset
- I_VGA_READ  in  1  VGA scan-out owns SRAM this cycle (VIDEO_ON)
- I_VGA_ADDR  in  ADDR_WIDTH  VGA read address
- O_VGA_DATA  out  DATA_WIDTH  SRAM data bus, combinational when I_VGA_READ=1, else 0
- I_REQ  in  NUM_CLIENTS  per-client request level
- I_WE  in  NUM_CLIENTS  per-client write (1) / read (0)
- I_ADDR  in  NUM_CLIENTS*ADDR_WIDTH  packed client addresses, client i at slice i
- I_WDATA  in  NUM_CLIENTS*DATA_WIDTH  packed client write data
- O_GNT  out  NUM_CLIENTS  one-hot grant pulse
- O_RVALID  out  NUM_CLIENTS  one-hot read-data-valid pulse
- O_RDATA  out  DATA_WIDTH  read data, shared by all clients
- IO_SRAM_DQ  inout  DATA_WIDTH  SRAM data bus
- O_SRAM_ADDR  out  ADDR_WIDTH  SRAM address
- O_SRAM_UB_N, O_SRAM_LB_N  out  1  tied 0
- O_SRAM_CE_N  out  1  tied 0
- O_SRAM_WE_N  out  1  write strobe, active low
- O_SRAM_OE_N  out  1  output enable, active low

## Operation
- **Access register (AR):** holds valid, client id, we, addr and wdata.
- **Grant rule:** in cycle t, a grant is issued iff all of the following hold:
  - I_VGA_READ=0
  - some I_REQ bit is set
  - AR is empty, or AR drains in cycle t
- **On grant:** O_GNT[i]=1 for exactly that cycle. The client's addr, we and wdata are captured into AR at the edge ending t. The client must hold REQ, WE, ADDR and WDATA stable until it sees GNT. REQ may stay high for back-to-back accesses.
- **Drain:** AR is valid and I_VGA_READ=0.
  - SRAM pins are driven from AR.
  - Write: WE_N=0, OE_N=1, DQ driven with wdata.
  - Read: WE_N=1, OE_N=0, DQ high-Z, and DQ is captured into O_RDATA.
- **VGA cycle:** I_VGA_READ=1.
  - O_SRAM_ADDR=I_VGA_ADDR, OE_N=0, WE_N=1, DQ high-Z.
  - No grant is issued and no drain occurs. AR holds its contents unchanged, so nothing is lost or duplicated.
- **Idle:** no access pending and no VGA cycle. Pins show WE_N=1, OE_N=1, DQ high-Z, and O_SRAM_ADDR holds its last value.
- **Round-robin:** rr_ptr holds the last granted id. The search order is rr_ptr+1 upward, wrapping modulo NUM_CLIENTS. rr_ptr updates on every grant.
- **Reset:** synchronous I_RST=1.
  - rr_ptr=NUM_CLIENTS-1, so client 0 wins first.
  - AR cleared, O_GNT=0, O_RVALID=0, O_RDATA=0, O_SRAM_ADDR=0, WE_N=1, OE_N=1, DQ high-Z.
  - Reset mid-access drops the AR contents. No RVALID is ever issued for them.

## Timing
- **Read latency:** grant in cycle t, SRAM access in t+1, O_RVALID[i] and O_RDATA valid in t+2, each for one cycle. Every VGA cycle between grant and drain adds one cycle.
- **Write latency:** grant in t, SRAM write in t+1. No response pulse is issued.
- **Throughput:** one access per cycle with no VGA activity. A client holding REQ alone receives GNT every cycle.
- **Simultaneous events:**
  - Grant and drain in the same cycle are permitted.
  - VGA_READ rising in the cycle after a grant stalls the drain.
  - A grant to client i in cycle t+1 never coincides with RVALID for client i's own earlier read. RVALID is registered one cycle after the drain.
- O_RDATA holds its value between RVALID pulses.

## Configuration
- **SRAM_ARB_FIXED_PRIO_EN:**
  - Defined: fixed priority, lowest requesting index wins, and rr_ptr is removed.
  - Undefined (default): round-robin as specified above.

## Test plan
- **Reset:** assert I_RST for 2 cycles mid-access.
  - Outputs at reset values: GNT=0, RVALID=0, RDATA=0, WE_N=1, OE_N=1, DQ=Z.
  - The dropped read never produces RVALID.
- **Write then read:** client 2 writes 0xBEEF to 0x00123, then reads it back.
  - WE_N=0 with ADDR=0x00123 in the cycle after the write GNT.
  - RVALID[2] and RDATA=0xBEEF two cycles after the read GNT.
- **Round-robin:** all 4 REQ held high for 8 cycles with VGA idle.
  - GNT sequence 0,1,2,3,0,1,2,3.
  - With SRAM_ARB_FIXED_PRIO_EN defined: GNT=0001 every cycle.
- **VGA preemption:** client 1 read granted, then I_VGA_READ=1 for 3 cycles starting the next cycle.
  - SRAM_ADDR follows I_VGA_ADDR during those 3 cycles, with no GNT.
  - Client 1's access drains on the 4th cycle and RVALID[1] follows one cycle later.
- **Single client back-to-back:** only client 0 requests, 5 reads to addresses 0..4.
  - 5 consecutive GNT pulses.
  - 5 consecutive RVALID[0] pulses, starting 2 cycles after the first GNT, with data matching preloaded memory.
- **Idle bus:** REQ=0 and VGA idle for 10 cycles.
  - WE_N=OE_N=1 and DQ high-Z throughout.
